// File: rtl/mmio_timer.sv
// Memory-mapped prescaled down-counter on the CPU data port, with one-shot and
// periodic modes, a sticky expiry flag and a level interrupt.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory_address2,
    input  logic        memory_write_enable2,
    input  logic [31:0] memory_wdata2,
    output logic [31:0] memory_rdata2,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_LOAD     = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RUNNING = 1'b1;

    logic        r_en;
    logic        r_reload;
    logic        r_irq_en;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_expired;
    logic [15:0] r_prescale;
    logic [15:0] r_pcnt;

    logic [4:0]  w_offset;
    logic [2:0]  w_idx;
    logic        w_hit;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_wr_prescale;
    logic [0:0]  w_state;
    logic        w_tick;
    logic        w_expire;
    logic [1:0]  w_unused_addr;

    // Byte lanes are not decoded; every access is treated as a full word.
    assign w_unused_addr = memory_address2[1:0];
    assign w_offset      = memory_address2[4:0];
    assign w_idx         = w_offset[4:2];
    assign w_hit         = (memory_address2[31:5] == BASE_ADDR[31:5]) && (w_offset < 5'h14);
    assign hit           = w_hit;

    assign w_wr          = w_hit && memory_write_enable2;
    assign w_wr_ctrl     = w_wr && (w_idx == REG_CTRL);
    assign w_wr_load     = w_wr && (w_idx == REG_LOAD);
    assign w_wr_count    = w_wr && (w_idx == REG_COUNT);
    assign w_wr_status   = w_wr && (w_idx == REG_STATUS);
    assign w_wr_prescale = w_wr && (w_idx == REG_PRESCALE);

    assign w_state  = r_en ? ST_RUNNING : ST_IDLE;
    assign w_tick   = (w_state == ST_RUNNING) && (r_pcnt == r_prescale);
    assign w_expire = w_tick && (r_count == 32'd0);

    assign irq = r_expired && r_irq_en;

    always_comb begin
        memory_rdata2 = 32'h0;
        if (w_hit) begin
            case (w_idx)
                REG_CTRL:     memory_rdata2 = {29'h0, r_irq_en, r_reload, r_en};
                REG_LOAD:     memory_rdata2 = r_load;
                REG_COUNT:    memory_rdata2 = r_count;
                REG_STATUS:   memory_rdata2 = {31'h0, r_expired};
                REG_PRESCALE: memory_rdata2 = {16'h0, r_prescale};
                default:      memory_rdata2 = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en       <= 1'b0;
            r_reload   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_load     <= 32'h0;
            r_count    <= 32'h0;
            r_expired  <= 1'b0;
            r_prescale <= 16'h0;
            r_pcnt     <= 16'h0;
        end else begin
            // A software CTRL write overrides the one-shot auto-stop.
            if (w_wr_ctrl) begin
                r_en     <= memory_wdata2[0];
                r_reload <= memory_wdata2[1];
                r_irq_en <= memory_wdata2[2];
            end else if (w_expire && !r_reload) begin
                r_en <= 1'b0;
            end

            if (w_wr_load) begin
                r_load <= memory_wdata2;
            end

            if (w_wr_prescale) begin
                r_prescale <= memory_wdata2[15:0];
            end

            // Reload samples the LOAD value from before any same-cycle write.
            if (w_wr_count) begin
                r_count <= memory_wdata2;
            end else if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else if (r_reload) begin
                    r_count <= r_load;
                end
            end

            // Set beats clear so an expiry landing on a clear is not lost.
            r_expired <= w_expire || (r_expired && !(w_wr_status && memory_wdata2[0]));

            if (w_wr_count || (w_wr_ctrl && memory_wdata2[0] && !r_en)) begin
                r_pcnt <= 16'h0;
            end else if ((w_state == ST_IDLE) || w_tick) begin
                r_pcnt <= 16'h0;
            end else begin
                r_pcnt <= r_pcnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that responds to the CPU's data port (address bus 2) as a second target alongside the 64-byte `MEMORY`. The CPU is the initiator on this port; `mmio_timer` decodes its address window, accepts writes, and returns register reads. Internally it runs a prescaled down-counter with one-shot and periodic modes, a sticky expiry flag, and an interrupt output. Its default window starts directly above the 64-byte RAM.

## Interface
- `BASE_ADDR`, 32'h0000_0040, byte address of the register window; must be 32-byte aligned.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `memory_address2`  input  32  CPU data-port byte address.
- `memory_write_enable2`  input  1  write strobe, sampled at `posedge clk`.
- `memory_wdata2`  input  32  CPU write data.
- `memory_rdata2`  output  32  read data; combinational from address and registers.
- `hit`  output  1  address falls in a valid register; the system read-data mux uses this.
- `irq`  output  1  interrupt, level high: `EXPIRED & IRQ_EN`.

## Operation
- **Decode.**
  - `hit` = (`memory_address2[31:5]` == `BASE_ADDR[31:5]`) && (offset < 5'h14), where offset = `memory_address2[4:0]`.
  - `address[1:0]` is ignored. Only full-word access is supported.
- **Register map** (offset, field, access):
  - 0x00 CTRL: bit0 EN, bit1 RELOAD (1 = periodic), bit2 IRQ_EN. R/W. Other bits read 0.
  - 0x04 LOAD: 32-bit reload value. R/W.
  - 0x08 COUNT: current count. A read returns the live value. A write loads COUNT and zeroes the prescaler.
  - 0x0C STATUS: bit0 EXPIRED. Sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
  - 0x10 PRESCALE: 16-bit, bits[15:0]. R/W. Upper bits read 0.
- **Reads.** `memory_rdata2` = selected register when `hit`, else 32'h0. Zero-latency, no handshake.
- **Writes.** Take effect at `posedge clk` when `hit && memory_write_enable2`. Writes outside the window are ignored.
- **Prescaler.**
  - `pcnt` (16-bit) increments each cycle while EN = 1.
  - When `pcnt` == PRESCALE: assert `tick`, then `pcnt` returns to 0. A tick therefore occurs every PRESCALE+1 cycles.
  - `pcnt` is held at 0 while EN = 0.
  - A CTRL write that sets EN 0→1 zeroes `pcnt`.
- **States** (derived from EN): IDLE (EN = 0) and RUNNING (EN = 1).
  - RUNNING, tick, COUNT != 0: COUNT decrements by 1.
  - RUNNING, tick, COUNT == 0:
    - EXPIRED is set to 1.
    - If RELOAD = 1: COUNT ← LOAD, stay RUNNING.
    - If RELOAD = 0: EN ← 0 (go to IDLE), COUNT stays 0.
  - Result: the period is (LOAD+1)·(PRESCALE+1) cycles.
- **Simultaneous events.**
  - COUNT write and tick in the same cycle: the write wins.
  - STATUS clear and new expiry in the same cycle: EXPIRED ends at 1. Set wins; no event is lost.
  - CTRL write and one-shot auto-clear of EN in the same cycle: the CTRL write value wins. EXPIRED still sets.
  - LOAD write and reload in the same cycle: COUNT takes the old LOAD.
- **Arithmetic.** All unsigned. COUNT never underflows, because the decrement is gated by COUNT != 0.

## Timing
- **Reset values.**
  - CTRL, LOAD, COUNT, STATUS, PRESCALE, `pcnt` = 0.
  - `irq` = 0.
  - `memory_rdata2` = 0 unless the address hits a register, which then reads its reset value of 0.
- **Reset mid-count.** Asserting `reset` at any time clears all state immediately (asynchronous). The counter stays in IDLE until software writes EN.
- **Write latency.** A register written at edge N is visible on `memory_rdata2` in cycle N+1.
- **First tick.** With the EN write at edge N, the first tick occurs at edge N+PRESCALE+1.
- **irq timing.** `irq` rises in the cycle after the expiring edge and stays high until EXPIRED is cleared or IRQ_EN is written 0.

## Test plan
- **Reset.** Assert `reset` asynchronously between clock edges.
  - Required: all outputs go to 0 immediately.
  - Required: reads of 0x40–0x50 return 0 with `hit` = 1; read of 0x54 gives `hit` = 0, rdata 0.
- **One-shot.** PRESCALE = 0, LOAD unused, COUNT = 3, CTRL = 0x5.
  - Required: EXPIRED and `irq` = 1 after exactly 4 ticks.
  - Required: CTRL reads 0x4 and COUNT holds 0.
  - Writing STATUS = 1 drops `irq` next cycle.
- **Periodic with prescaler.** PRESCALE = 2, LOAD = 1, COUNT = 1, CTRL = 0x3.
  - Required: expiry edges occur every 6 cycles; COUNT sequence 1,0,1,0…
- **Set-wins collision.** Write STATUS = 1 on the same edge as an expiry.
  - Required: EXPIRED reads 1 afterwards.
- **Write-wins collision.** Write COUNT = 0x10 on a tick edge.
  - Required: COUNT reads 0x10, not the decremented value.
  - Required: the next tick is PRESCALE+1 cycles later.
- **Decode isolation.** Write 0xDEADBEEF to 0x3C (RAM) and to 0x60.
  - Required: no timer register changes and `hit` = 0.
  - Write to 0x45 (misaligned): updates LOAD.
